// File: rtl/sorted_remove10.sv
// Sequential delete-and-compact for a sorted array: removes up to NDEL sorted keys in one merge-style pass.
// Optional macro REMOVE_ALL_DUP_EN: each key removes every equal entry instead of just one.
module sorted_remove10 #(
    parameter int               WIDTH = 16,
    parameter int               DEPTH = 100,
    parameter int               NDEL  = 10,
    parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b1}}
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DEPTH*WIDTH-1:0]           array_in,
    input  logic [NDEL*WIDTH-1:0]            keys,
    input  logic [$clog2(NDEL+1)-1:0]        num_keys,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DEPTH*WIDTH-1:0]           result,
    output logic [NDEL-1:0]                  found,
    output logic [$clog2(DEPTH+1)-1:0]       rm_cnt,
    output logic [$clog2(DEPTH+1)-1:0]       len
);
    localparam int IW = $clog2(DEPTH+1);
    localparam int KW = $clog2(NDEL+1);
    localparam logic [KW-1:0] NDEL_K  = KW'(NDEL);
    localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
    localparam logic [IW-1:0] LAST_I  = IW'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] src   [DEPTH];
    logic [WIDTH-1:0] key_r [NDEL];
    logic [WIDTH-1:0] res_r [DEPTH];
    logic [KW-1:0]    nk, k, k_next;
    logic [IW-1:0]    i, wr;

    logic [WIDTH-1:0] cur, key_cur, key_nxt;
    logic             keys_done, take, drop, last, next_dup;

    always_comb begin
        k_next    = k + 1'b1;
        cur       = (i < DEPTH_I) ? src[i] : '0;
        key_cur   = (k < NDEL_K) ? key_r[k] : '0;
        key_nxt   = (k_next < NDEL_K) ? key_r[k_next] : '0;
        keys_done = (k == nk);
        take      = keys_done || (cur < key_cur);
        drop      = !keys_done && (cur == key_cur);
        last      = (take || drop) && (i == LAST_I);
        next_dup  = (k_next < nk) && (key_nxt == key_cur);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = SCAN;
            end
            SCAN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                src[j]   <= '0;
                res_r[j] <= '0;
            end
            for (int j = 0; j < NDEL; j++) key_r[j] <= '0;
            nk     <= '0;
            k      <= '0;
            i      <= '0;
            wr     <= '0;
            found  <= '0;
            rm_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < DEPTH; j++) begin
                            src[j]   <= array_in[j*WIDTH +: WIDTH];
                            res_r[j] <= FILL;
                        end
                        for (int j = 0; j < NDEL; j++) key_r[j] <= keys[j*WIDTH +: WIDTH];
                        nk     <= (num_keys > NDEL_K) ? NDEL_K : num_keys;
                        k      <= '0;
                        i      <= '0;
                        wr     <= '0;
                        found  <= '0;
                        rm_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        res_r[wr] <= cur;
                        wr        <= wr + 1'b1;
                        i         <= i + 1'b1;
                    end else if (drop) begin
                        found[k] <= 1'b1;
                        rm_cnt   <= rm_cnt + 1'b1;
                        i        <= i + 1'b1;
`ifdef REMOVE_ALL_DUP_EN
                        // Hold the key for further duplicates, but walk over repeated keys so they report found too.
                        if (next_dup) k <= k_next;
`else
                        k <= k_next;
`endif
                    end else begin
                        k <= k_next;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_out
        assign result[j*WIDTH +: WIDTH] = res_r[j];
    end

    assign len = DEPTH_I - rm_cnt;

endmodule

// File: tb/tb_sorted_remove10.sv
// Directed self-checking bench for sorted_remove10 (honours REMOVE_ALL_DUP_EN when defined).
module tb_sorted_remove10;
    localparam int W = 16;
    localparam int D = 100;
    localparam int N = 10;
    localparam logic [W-1:0] FILLV = 16'hFFFF;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [D*W-1:0] array_in = '0;
    logic [N*W-1:0] keys = '0;
    logic [3:0]     num_keys = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [D*W-1:0] result;
    logic [N-1:0]   found;
    logic [6:0]     rm_cnt;
    logic [6:0]     len;

    int total = 0;
    int bad = 0;

    sorted_remove10 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .array_in(array_in), .keys(keys), .num_keys(num_keys),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .found(found), .rm_cnt(rm_cnt), .len(len)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] el(input logic [D*W-1:0] v, input int j);
        return v[j*W +: W];
    endfunction

    function automatic logic [D*W-1:0] ramp();
        logic [D*W-1:0] a;
        for (int j = 0; j < D; j++) a[j*W +: W] = W'(2*j);
        return a;
    endfunction

    task automatic start_op(input logic [D*W-1:0] a, input logic [N*W-1:0] kk, input logic [3:0] n);
        @(negedge clk);
        array_in = a;
        keys     = kk;
        num_keys = n;
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat = cycles from the accept edge to the first cycle showing out_valid; 0 on timeout
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (result !== '0) begin bad++; $display("[TB] FAIL reset_result got_el0=%h want all 0", el(result, 0)); end
        total++; if (found !== '0) begin bad++; $display("[TB] FAIL reset_found got=%b want=0", found); end
        total++; if (rm_cnt !== 7'd0) begin bad++; $display("[TB] FAIL reset_rm_cnt got=%0d want=0", rm_cnt); end
        total++; if (len !== 7'd100) begin bad++; $display("[TB] FAIL reset_len got=%0d want=100", len); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [N*W-1:0] kk = '0;
        logic [W-1:0]   exp;
        int lat;
        kk[0*W +: W] = 16'd10;
        kk[1*W +: W] = 16'd50;
        kk[2*W +: W] = 16'd198;
        start_op(ramp(), kk, 4'd3);
        wait_done(lat);
        total++; if (lat != 101) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=101", lat); end
        total++; if (rm_cnt !== 7'd3) begin bad++; $display("[TB] FAIL basic_rm_cnt got=%0d want=3", rm_cnt); end
        total++; if (len !== 7'd97) begin bad++; $display("[TB] FAIL basic_len got=%0d want=97", len); end
        total++; if (found !== 10'b0000000111) begin bad++; $display("[TB] FAIL basic_found got=%b want=0000000111", found); end
        for (int j = 0; j < D; j++) begin
            if (j < 5)       exp = W'(2*j);
            else if (j < 24) exp = W'(2*(j+1));
            else if (j < 97) exp = W'(2*(j+2));
            else             exp = FILLV;
            total++; if (el(result, j) !== exp) begin bad++; $display("[TB] FAIL basic_result[%0d] got=%0d want=%0d", j, el(result, j), exp); end
        end
        release_result();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_stall();
        logic [N*W-1:0] kk = '0;
        logic [W-1:0]   exp;
        int lat;
        kk[0*W +: W] = 16'd11;
        kk[1*W +: W] = 16'd50;
        start_op(ramp(), kk, 4'd2);
        wait_done(lat);
        total++; if (lat != 102) begin bad++; $display("[TB] FAIL stall_latency got=%0d want=102", lat); end
        total++; if (rm_cnt !== 7'd1) begin bad++; $display("[TB] FAIL stall_rm_cnt got=%0d want=1", rm_cnt); end
        total++; if (found !== 10'b0000000010) begin bad++; $display("[TB] FAIL stall_found got=%b want=0000000010", found); end
        for (int j = 0; j < D; j++) begin
            if (j < 25)      exp = W'(2*j);
            else if (j < 99) exp = W'(2*(j+1));
            else             exp = FILLV;
            total++; if (el(result, j) !== exp) begin bad++; $display("[TB] FAIL stall_result[%0d] got=%0d want=%0d", j, el(result, j), exp); end
        end
        release_result();
    endtask

    task automatic test_clamp();
        logic [N*W-1:0] kk = '0;
        logic [W-1:0]   exp;
        int lat;
        for (int k = 0; k < N; k++) kk[k*W +: W] = W'(2*k);
        start_op(ramp(), kk, 4'd15);
        wait_done(lat);
        total++; if (lat != 101) begin bad++; $display("[TB] FAIL clamp_latency got=%0d want=101", lat); end
        total++; if (rm_cnt !== 7'd10) begin bad++; $display("[TB] FAIL clamp_rm_cnt got=%0d want=10", rm_cnt); end
        total++; if (found !== 10'h3FF) begin bad++; $display("[TB] FAIL clamp_found got=%b want=1111111111", found); end
        for (int j = 0; j < D; j++) begin
            exp = (j < 90) ? W'(2*(j+10)) : FILLV;
            total++; if (el(result, j) !== exp) begin bad++; $display("[TB] FAIL clamp_result[%0d] got=%0d want=%0d", j, el(result, j), exp); end
        end
        release_result();
    endtask

    task automatic test_dup();
        logic [D*W-1:0] a;
        logic [N*W-1:0] kk = '0;
        logic [W-1:0]   exp;
        int lat;
        int exp_rm;
        for (int j = 0; j < D; j++) a[j*W +: W] = 16'd7;
        for (int k = 0; k < 3; k++) kk[k*W +: W] = 16'd7;
`ifdef REMOVE_ALL_DUP_EN
        exp_rm = 100;
`else
        exp_rm = 3;
`endif
        start_op(a, kk, 4'd3);
        wait_done(lat);
        total++; if (lat != 101) begin bad++; $display("[TB] FAIL dup_latency got=%0d want=101", lat); end
        total++; if (int'(rm_cnt) != exp_rm) begin bad++; $display("[TB] FAIL dup_rm_cnt got=%0d want=%0d", rm_cnt, exp_rm); end
        total++; if (found !== 10'b0000000111) begin bad++; $display("[TB] FAIL dup_found got=%b want=0000000111", found); end
        for (int j = 0; j < D; j++) begin
            exp = (j < D - exp_rm) ? 16'd7 : FILLV;
            total++; if (el(result, j) !== exp) begin bad++; $display("[TB] FAIL dup_result[%0d] got=%0d want=%0d", j, el(result, j), exp); end
        end
        release_result();
    endtask

    task automatic test_nokeys_hold();
        logic [D*W-1:0] a;
        logic [N*W-1:0] kk = '0;
        int lat;
        for (int j = 0; j < D; j++) a[j*W +: W] = W'(3*j + 1);
        kk[0*W +: W] = 16'd4;
        start_op(a, kk, 4'd0);
        wait_done(lat);
        total++; if (lat != 101) begin bad++; $display("[TB] FAIL nokeys_latency got=%0d want=101", lat); end
        for (int c = 0; c < 20; c++) begin
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_hs cyc=%0d got out_valid=%b in_ready=%b want 1/0", c, out_valid, in_ready); end
            total++; if (result !== a) begin bad++; $display("[TB] FAIL hold_result cyc=%0d got_el1=%0d want=%0d", c, el(result, 1), el(a, 1)); end
            total++; if (found !== '0 || rm_cnt !== 7'd0 || len !== 7'd100) begin bad++; $display("[TB] FAIL hold_counts cyc=%0d got found=%b rm=%0d len=%0d want 0/0/100", c, found, rm_cnt, len); end
            @(negedge clk);
        end
        release_result();
    endtask

    task automatic test_reset_mid_scan();
        logic [N*W-1:0] kk = '0;
        kk[0*W +: W] = 16'd10;
        start_op(ramp(), kk, 4'd1);
        repeat (40) @(negedge clk);
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midscan_busy got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midscan_abort got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        total++; if (rm_cnt !== 7'd0 || result !== '0) begin bad++; $display("[TB] FAIL midscan_clear got rm=%0d el0=%0d want 0/0", rm_cnt, el(result, 0)); end
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
    endtask

    // The IDLE cycle that accepts is also the first cycle of the next op, so accepts are 102 cycles apart.
    task automatic test_back_to_back();
        int acc [4];
        int n_acc = 0;
        int n_res = 0;
        logic [N*W-1:0] kk = '0;
        kk[0*W +: W] = 16'd10;
        kk[1*W +: W] = 16'd50;
        kk[2*W +: W] = 16'd198;
        @(negedge clk);
        array_in  = ramp();
        keys      = kk;
        num_keys  = 4'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 600 && n_res < 3; c++) begin
            if (in_ready && in_valid && n_acc < 4) begin
                acc[n_acc] = c;
                n_acc++;
            end
            if (out_valid) begin
                n_res++;
                total++; if (rm_cnt !== 7'd3 || el(result, 96) !== 16'd196) begin bad++; $display("[TB] FAIL b2b_result n=%0d got rm=%0d el96=%0d want 3/196", n_res, rm_cnt, el(result, 96)); end
                if (n_res == 3) in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++; if (n_res != 3 || n_acc < 3) begin bad++; $display("[TB] FAIL b2b_count got results=%0d accepts=%0d want 3/3", n_res, n_acc); end
        if (n_acc >= 3) begin
            total++; if (acc[1] - acc[0] != 102) begin bad++; $display("[TB] FAIL b2b_period0 got=%0d want=102", acc[1] - acc[0]); end
            total++; if (acc[2] - acc[1] != 102) begin bad++; $display("[TB] FAIL b2b_period1 got=%0d want=102", acc[2] - acc[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_clamp();
        test_dup();
        test_nokeys_hold();
        test_reset_mid_scan();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
